run_ctrl: RTL
=============

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 The block SHALL have parameter ENTRY0, default 12'd0, meaning the program-0 entry PC.
REQ-002 The block SHALL have parameter ENTRY1, default 12'd256, meaning the program-1 entry PC.
REQ-003 The block SHALL have parameter ENTRY2, default 12'd512, meaning the program-2 entry PC.
REQ-004 The block SHALL have parameter MAX_CYCLES, default 16'd4000, meaning the watchdog limit in RUN cycles (legal range 1..65535).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: launch request, sampled each edge.
REQ-008 The block SHALL have port prog_sel, input, 2 bits: program select, captured at launch.
REQ-009 The block SHALL have port halt_seen, input, 1 bit: decoded halt instruction from the core controller.
REQ-010 The block SHALL have port pc_load, output, 1 bit: forces the PC to pc_load_val this cycle.
REQ-011 The block SHALL have port pc_load_val, output, 12 bits: entry address.
REQ-012 The block SHALL have port cpu_en, output, 1 bit: core enable; PC, reg file and data-mem writes are gated by it.
REQ-013 The block SHALL have port busy, output, 1 bit: high in LOAD or RUN.
REQ-014 The block SHALL have port done, output, 1 bit: program finished.
REQ-015 The block SHALL have port timeout, output, 1 bit: the run ended by watchdog.
REQ-016 The block SHALL have port bad_sel, output, 1 bit: the launch used prog_sel=3.
REQ-017 The block SHALL have port cycle_count, output, 16 bits: RUN cycles of the last or current run.

Function
REQ-018 The block SHALL be a Moore FSM with states IDLE, LOAD, RUN and DONE; all outputs are registered or decoded from state only.
REQ-019 In IDLE, start=1 with prog_sel in 0..2 SHALL move the FSM to LOAD, capture prog_sel, clear cycle_count and clear timeout and bad_sel.
REQ-020 In IDLE or DONE, start=1 with prog_sel=3 SHALL move the FSM to DONE with bad_sel=1, timeout=0 and cycle_count=0, and SHALL not enter LOAD or RUN.
REQ-021 LOAD SHALL last exactly one cycle with pc_load=1, pc_load_val=ENTRYn for the captured select, and cpu_en=0, then move to RUN.
REQ-022 Outside LOAD, pc_load SHALL be 0 and pc_load_val SHALL be 12'd0.
REQ-023 In RUN, cpu_en SHALL be 1 and cycle_count SHALL increment by 1 on every edge spent in RUN, including the edge that samples halt_seen.
REQ-024 In RUN, halt_seen=1 SHALL move the FSM to DONE on the next edge, so cpu_en is 0 from the following cycle.
REQ-025 In RUN, if cycle_count reaches MAX_CYCLES-1 on this edge without halt_seen, the FSM SHALL move to DONE with timeout=1.
REQ-026 If halt_seen and the watchdog limit occur on the same edge, halt SHALL win and timeout SHALL stay 0.
REQ-027 In DONE, done SHALL be 1, cpu_en SHALL be 0, and cycle_count, timeout and bad_sel SHALL hold their values.
REQ-028 In DONE, start=1 SHALL relaunch exactly as from IDLE (REQ-019/020), and done SHALL drop in the LOAD cycle.
REQ-029 start SHALL be ignored in LOAD and RUN; the run is not restarted.
REQ-030 halt_seen SHALL be ignored outside RUN.
REQ-031 busy SHALL be 1 exactly in LOAD and RUN, and busy and done SHALL never be 1 together.
REQ-032 cycle_count SHALL never wrap, since the watchdog bounds it at MAX_CYCLES.

Reset
REQ-033 reset=1 at an edge SHALL force IDLE from any state, including mid-RUN, and clear pc_load, pc_load_val, cpu_en, busy, done, timeout, bad_sel and cycle_count to 0.
REQ-034 reset SHALL have priority over start and halt_seen on the same edge.
REQ-035 The first edge after reset deasserts SHALL evaluate start normally.

Verification
REQ-036 The bench SHALL cover a normal run: prog_sel=1, start pulse, halt_seen at RUN cycle 10 -> one LOAD cycle with pc_load_val=256, cpu_en high for 10 cycles, then done=1, cycle_count=10, timeout=0.
REQ-037 The bench SHALL cover the watchdog: MAX_CYCLES=20, prog_sel=0, halt never asserted -> DONE after 20 RUN cycles, timeout=1, cycle_count=20.
REQ-038 The bench SHALL cover simultaneous events: MAX_CYCLES=20 with halt_seen on RUN cycle 20 -> timeout=0, done=1, cycle_count=20.
REQ-039 The bench SHALL cover a bad select: prog_sel=3 with start -> DONE next edge, bad_sel=1, pc_load never 1, cpu_en never 1.
REQ-040 The bench SHALL cover reset mid-run and relaunch: reset asserted at RUN cycle 5 -> all outputs 0 next cycle; then prog_sel=2 with start -> pc_load_val=512, cycle_count restarts from 0.
REQ-041 The bench SHALL cover launch-only behaviour: start held high through LOAD and RUN -> no relaunch during the run; start still high in DONE -> new LOAD the following cycle.

Source files
------------

// File: rtl/run_ctrl.sv
// run_ctrl: launch / watchdog controller for the core.
// A start pulse in IDLE or DONE selects one of three program entry points.
// The block loads the PC for one cycle and then enables the core until a halt
// is decoded or the watchdog expires. Outputs are Moore: either decoded from
// the state or held in registers.
//
// Handshake: start is a level sampled on every rising edge. It is acted on
// only in IDLE or DONE. halt_seen is a level sampled only in RUN. Neither
// input is acknowledged; the launch is visible as busy/pc_load, and
// completion is visible as done.
module run_ctrl #(
  parameter logic [11:0] ENTRY0     = 12'd0,
  parameter logic [11:0] ENTRY1     = 12'd256,
  parameter logic [11:0] ENTRY2     = 12'd512,
  parameter logic [15:0] MAX_CYCLES = 16'd4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  prog_sel,
  input  logic        halt_seen,
  output logic        pc_load,
  output logic [11:0] pc_load_val,
  output logic        cpu_en,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        bad_sel,
  output logic [15:0] cycle_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state;
  logic [1:0]  sel_q;
  logic [15:0] count_q;
  logic        timeout_q;
  logic        bad_sel_q;

  // The watchdog fires on the edge that ends the MAX_CYCLES-th RUN cycle.
  logic        limit_hit;
  assign limit_hit = (count_q == (MAX_CYCLES - 16'd1));

  // FSM and run-status registers; reset has priority over every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sel_q     <= 2'd0;
      count_q   <= 16'd0;
      timeout_q <= 1'b0;
      bad_sel_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            count_q   <= 16'd0;
            timeout_q <= 1'b0;
            if (prog_sel == 2'd3) begin
              // An illegal select finishes immediately and never runs the core.
              state     <= ST_DONE;
              bad_sel_q <= 1'b1;
            end else begin
              state     <= ST_LOAD;
              sel_q     <= prog_sel;
              bad_sel_q <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          // Every RUN edge counts, including the one that sees the halt.
          count_q <= count_q + 16'd1;
          if (halt_seen) begin
            state <= ST_DONE;
          end else if (limit_hit) begin
            state     <= ST_DONE;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Entry address is only driven during the single LOAD cycle.
  always_comb begin
    pc_load_val = 12'd0;
    if (state == ST_LOAD) begin
      case (sel_q)
        2'd0:    pc_load_val = ENTRY0;
        2'd1:    pc_load_val = ENTRY1;
        default: pc_load_val = ENTRY2;
      endcase
    end
  end

  assign pc_load     = (state == ST_LOAD);
  assign cpu_en      = (state == ST_RUN);
  assign busy        = (state == ST_LOAD) || (state == ST_RUN);
  assign done        = (state == ST_DONE);
  assign timeout     = timeout_q;
  assign bad_sel     = bad_sel_q;
  assign cycle_count = count_q;

endmodule
